// File: rtl/n1_intc.sv
// n1_intc: edge-triggered interrupt controller feeding the N1 aggregator with a held ISR address.
// Define N1_INTC_RR_EN for round-robin arbitration; the default is fixed lowest-index priority.
module n1_intc #(
  parameter int          SRC_CNT    = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter int          VEC_STRIDE = 4
) (
  input  logic                       clk_i,
  input  logic                       async_rst_i,
  input  logic [SRC_CNT-1:0]         irq_src_i,
  input  logic                       cfg_mask_we_i,
  input  logic [SRC_CNT-1:0]         cfg_mask_dat_i,
  input  logic                       cfg_clr_we_i,
  input  logic [SRC_CNT-1:0]         cfg_clr_dat_i,
  input  logic                       irq_ack_i,
  output logic [15:0]                irq_req_adr_o,
  output logic [$clog2(SRC_CNT)-1:0] irq_idx_o,
  output logic [SRC_CNT-1:0]         prb_pend_o,
  output logic [SRC_CNT-1:0]         prb_mask_o,
  output logic [1:0]                 prb_state_o
);

  localparam int IW = $clog2(SRC_CNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t             r_state;
  logic [SRC_CNT-1:0] r_src_prev;
  logic [SRC_CNT-1:0] r_pend;
  logic [SRC_CNT-1:0] r_mask;
  logic [15:0]        r_adr;
  logic [IW-1:0]      r_idx;

  logic [SRC_CNT-1:0] w_rise;
  logic [SRC_CNT-1:0] w_clr;
  logic [SRC_CNT-1:0] w_pend_next;
  logic [SRC_CNT-1:0] w_mask_next;
  logic [SRC_CNT-1:0] w_cand;
  logic               w_ack;
  logic               w_keep;
  logic               w_win_vld;
  logic [IW-1:0]      w_win_idx;
  logic [15:0]        w_win_adr;

  assign w_ack       = (r_state == ST_PRESENT) && irq_ack_i;
  assign w_rise      = irq_src_i & ~r_src_prev;
  assign w_mask_next = cfg_mask_we_i ? cfg_mask_dat_i : r_mask;
  assign w_cand      = r_pend & r_mask;

  // A new edge on a bit always beats any clear of that bit in the same cycle.
  for (genvar gi = 0; gi < SRC_CNT; gi++) begin : g_pend
    assign w_clr[gi]       = (w_ack && (r_idx == IW'(gi))) ||
                             (cfg_clr_we_i && cfg_clr_dat_i[gi]);
    assign w_pend_next[gi] = w_rise[gi] | (r_pend[gi] & ~w_clr[gi]);
  end

  // Presented source must still be pending and enabled after this edge's updates.
  assign w_keep = w_pend_next[r_idx] & w_mask_next[r_idx];

`ifdef N1_INTC_RR_EN
  logic [IW-1:0] r_ptr;

  always_comb begin
    int j;
    j         = 0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    // Scan from the farthest offset down so the one nearest the pointer wins.
    for (int off = SRC_CNT - 1; off >= 0; off--) begin
      j = int'(r_ptr) + off;
      if (j >= SRC_CNT) j = j - SRC_CNT;
      if (w_cand[j]) begin
        w_win_vld = 1'b1;
        w_win_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_ptr <= '0;
    end else if (w_ack) begin
      r_ptr <= (int'(r_idx) == SRC_CNT - 1) ? '0 : r_idx + 1'b1;
    end
  end
`else
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = SRC_CNT - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        w_win_vld = 1'b1;
        w_win_idx = IW'(k);
      end
    end
  end
`endif

  assign w_win_adr = VEC_BASE + 16'(w_win_idx) * 16'(VEC_STRIDE);

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_src_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_state    <= ST_IDLE;
      r_adr      <= '0;
      r_idx      <= '0;
    end else begin
      r_src_prev <= irq_src_i;
      r_pend     <= w_pend_next;
      r_mask     <= w_mask_next;
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_state <= ST_PRESENT;
            r_idx   <= w_win_idx;
            r_adr   <= w_win_adr;
          end
        end
        ST_PRESENT: begin
          // Ack takes precedence over a simultaneous cfg clear of the same bit.
          if (irq_ack_i) begin
            r_state <= ST_HOLDOFF;
            r_adr   <= '0;
          end else if (!w_keep) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
          end
        end
        ST_HOLDOFF: begin
          if (w_win_vld) begin
            r_state <= ST_PRESENT;
            r_idx   <= w_win_idx;
            r_adr   <= w_win_adr;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_adr   <= '0;
        end
      endcase
    end
  end

  assign irq_req_adr_o = r_adr;
  assign irq_idx_o     = r_idx;
  assign prb_pend_o    = r_pend;
  assign prb_mask_o    = r_mask;
  assign prb_state_o   = r_state;

endmodule

// File: tb/tb_n1_intc.sv
// Directed bench for n1_intc: latency, priority, masking, clear/set races, holdoff and reset.
module tb_n1_intc;

  logic        clk_i = 1'b0;
  logic        async_rst_i;
  logic [7:0]  irq_src_i;
  logic        cfg_mask_we_i;
  logic [7:0]  cfg_mask_dat_i;
  logic        cfg_clr_we_i;
  logic [7:0]  cfg_clr_dat_i;
  logic        irq_ack_i;
  logic [15:0] irq_req_adr_o;
  logic [2:0]  irq_idx_o;
  logic [7:0]  prb_pend_o;
  logic [7:0]  prb_mask_o;
  logic [1:0]  prb_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  n1_intc #(.SRC_CNT(8), .VEC_BASE(16'h0100), .VEC_STRIDE(4)) u_dut (
    .clk_i          (clk_i),
    .async_rst_i    (async_rst_i),
    .irq_src_i      (irq_src_i),
    .cfg_mask_we_i  (cfg_mask_we_i),
    .cfg_mask_dat_i (cfg_mask_dat_i),
    .cfg_clr_we_i   (cfg_clr_we_i),
    .cfg_clr_dat_i  (cfg_clr_dat_i),
    .irq_ack_i      (irq_ack_i),
    .irq_req_adr_o  (irq_req_adr_o),
    .irq_idx_o      (irq_idx_o),
    .prb_pend_o     (prb_pend_o),
    .prb_mask_o     (prb_mask_o),
    .prb_state_o    (prb_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    cfg_mask_we_i  = 1'b1;
    cfg_mask_dat_i = m;
    tick();
    cfg_mask_we_i  = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] s);
    irq_src_i = s;
    tick();
    irq_src_i = '0;
  endtask

  task automatic ack_once();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  initial begin
    async_rst_i    = 1'b0;
    irq_src_i      = '0;
    cfg_mask_we_i  = 1'b0;
    cfg_mask_dat_i = '0;
    cfg_clr_we_i   = 1'b0;
    cfg_clr_dat_i  = '0;
    irq_ack_i      = 1'b0;
    #12;
    check("rst_adr",   32'(irq_req_adr_o), 32'h0);
    check("rst_idx",   32'(irq_idx_o),     32'h0);
    check("rst_state", 32'(prb_state_o),   32'h0);
    check("rst_pend",  32'(prb_pend_o),    32'h0);
    check("rst_mask",  32'(prb_mask_o),    32'h0);
    async_rst_i = 1'b1;

    // Single source 3: latency, ack, holdoff, back to idle
    write_mask(8'hFF);
    check("t1_mask", 32'(prb_mask_o), 32'hFF);
    pulse_src(8'h08);
    check("t1_pend_set", 32'(prb_pend_o),    32'h08);
    check("t1_adr_wait", 32'(irq_req_adr_o), 32'h0);
    tick();
    check("t1_adr",   32'(irq_req_adr_o), 32'h010C);
    check("t1_idx",   32'(irq_idx_o),     32'd3);
    check("t1_state", 32'(prb_state_o),   32'd1);
    ack_once();
    check("t1_hold_adr",   32'(irq_req_adr_o), 32'h0);
    check("t1_hold_state", 32'(prb_state_o),   32'd2);
    check("t1_pend_clr",   32'(prb_pend_o),    32'h0);
    tick();
    check("t1_idle_state", 32'(prb_state_o),   32'd0);
    check("t1_idle_adr",   32'(irq_req_adr_o), 32'h0);

    // Sources 5 and 2 together: 2 first, then 5 after one zero cycle
    pulse_src(8'h24);
    tick();
    check("t2_adr2", 32'(irq_req_adr_o), 32'h0108);
    check("t2_idx2", 32'(irq_idx_o),     32'd2);
    ack_once();
    check("t2_zero", 32'(irq_req_adr_o), 32'h0);
    check("t2_pend", 32'(prb_pend_o),    32'h20);
    tick();
    check("t2_adr5", 32'(irq_req_adr_o), 32'h0114);
    check("t2_idx5", 32'(irq_idx_o),     32'd5);
    ack_once();
    tick();
    check("t2_idle", 32'(prb_state_o), 32'd0);

    // Masked source stays pending without a request until unmasked
    write_mask(8'h00);
    pulse_src(8'h02);
    check("t3_pend", 32'(prb_pend_o),    32'h02);
    check("t3_adr0", 32'(irq_req_adr_o), 32'h0);
    tick();
    check("t3_adr1",  32'(irq_req_adr_o), 32'h0);
    check("t3_state", 32'(prb_state_o),   32'd0);
    write_mask(8'h02);
    check("t3_adr_wr", 32'(irq_req_adr_o), 32'h0);
    tick();
    check("t3_adr", 32'(irq_req_adr_o), 32'h0104);
    ack_once();
    tick();
    write_mask(8'hFF);

    // No pre-emption by higher priority; cfg clear drops the presented source
    pulse_src(8'h10);
    tick();
    check("t4_adr4", 32'(irq_req_adr_o), 32'h0110);
    pulse_src(8'h01);
    check("t4_hold_a", 32'(irq_req_adr_o), 32'h0110);
    check("t4_idx",    32'(irq_idx_o),     32'd4);
    tick();
    check("t4_hold_b", 32'(irq_req_adr_o), 32'h0110);
    ack_once();
    check("t4_zero", 32'(irq_req_adr_o), 32'h0);
    tick();
    check("t4_adr0", 32'(irq_req_adr_o), 32'h0100);
    ack_once();
    tick();
    pulse_src(8'h10);
    tick();
    check("t4_adr4b", 32'(irq_req_adr_o), 32'h0110);
    cfg_clr_we_i  = 1'b1;
    cfg_clr_dat_i = 8'h10;
    tick();
    cfg_clr_we_i  = 1'b0;
    cfg_clr_dat_i = '0;
    check("t4_clr_adr",   32'(irq_req_adr_o), 32'h0);
    check("t4_clr_state", 32'(prb_state_o),   32'd0);
    check("t4_clr_pend",  32'(prb_pend_o),    32'h0);

    // Edge on presented source during ack: set wins, re-presented after holdoff
    pulse_src(8'h40);
    tick();
    check("t5_adr6", 32'(irq_req_adr_o), 32'h0118);
    irq_src_i = 8'h40;
    irq_ack_i = 1'b1;
    tick();
    irq_src_i = '0;
    irq_ack_i = 1'b0;
    check("t5_pend",  32'(prb_pend_o),    32'h40);
    check("t5_zero",  32'(irq_req_adr_o), 32'h0);
    check("t5_state", 32'(prb_state_o),   32'd2);
    tick();
    check("t5_re_adr", 32'(irq_req_adr_o), 32'h0118);
    check("t5_re_idx", 32'(irq_idx_o),     32'd6);
    async_rst_i = 1'b0;
    #1;
    check("t5_rst_adr",   32'(irq_req_adr_o), 32'h0);
    check("t5_rst_idx",   32'(irq_idx_o),     32'h0);
    check("t5_rst_state", 32'(prb_state_o),   32'h0);
    check("t5_rst_pend",  32'(prb_pend_o),    32'h0);
    check("t5_rst_mask",  32'(prb_mask_o),    32'h0);
    async_rst_i = 1'b1;

    // Sources 0 and 1 kept pending: arbitration policy decides the order
    write_mask(8'hFF);
    pulse_src(8'h03);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp_idx;
`ifdef N1_INTC_RR_EN
      exp_idx = 3'(i % 2);
`else
      exp_idx = 3'd0;
`endif
      check($sformatf("t6_idx%0d", i), 32'(irq_idx_o),     32'(exp_idx));
      check($sformatf("t6_adr%0d", i), 32'(irq_req_adr_o), 32'h0100 + 32'(exp_idx) * 4);
      irq_src_i = 8'h01 << exp_idx;
      irq_ack_i = 1'b1;
      tick();
      irq_src_i = '0;
      irq_ack_i = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
